// File: rtl/avalonmm_mailbox_slave.sv
// rtl/avalonmm_mailbox_slave.sv - Avalon-MM mailbox responder with control/status, scratch and command/response FIFOs
module avalonmm_mailbox_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] avs_address,
  input  logic [DATA_WIDTH-1:0] avs_writedata,
  input  logic                  avs_write,
  input  logic                  avs_read,
  input  logic [3:0]            avs_byteenable,
  output logic [DATA_WIDTH-1:0] avs_readdata,
  output logic                  avs_readdatavalid,
  output logic                  avs_waitrequest,
  output logic                  go_pulse,
  input  logic                  done_in,
  output logic                  irq,
  output logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] resp_data,
  input  logic                  resp_valid,
  output logic                  resp_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  // Register state and next-state
  logic                  ready_q, ready_d;
  logic                  irq_en_q, irq_en_d;
  logic                  done_q, done_d;
  logic                  underflow_q, underflow_d;
  logic                  go_q, go_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] scratch_q [4];
  logic [DATA_WIDTH-1:0] scratch_d [4];
  logic [PW-1:0]         cmd_wptr_q, cmd_wptr_d, cmd_rptr_q, cmd_rptr_d;
  logic [CW-1:0]         cmd_cnt_q, cmd_cnt_d;
  logic [PW-1:0]         resp_wptr_q, resp_wptr_d, resp_rptr_q, resp_rptr_d;
  logic [CW-1:0]         resp_cnt_q, resp_cnt_d;
  logic [DATA_WIDTH-1:0] cmd_mem  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] resp_mem [FIFO_DEPTH];

  logic [2:0]            idx;
  logic                  cmd_full, cmd_empty, resp_full, resp_empty;
  logic                  wr_acc, rd_acc;
  logic                  cmd_push, cmd_pop, resp_push, resp_pop, resp_pop_req;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic                  unused_ok;

  assign idx        = avs_address[4:2];
  assign unused_ok  = ^{avs_address[ADDR_WIDTH-1:5], avs_address[1:0]};
  assign cmd_full   = (cmd_cnt_q == FULL_CNT);
  assign cmd_empty  = (cmd_cnt_q == '0);
  assign resp_full  = (resp_cnt_q == FULL_CNT);
  assign resp_empty = (resp_cnt_q == '0);

  // Stall only before the first post-reset edge, or when pushing into a full command FIFO
  assign avs_waitrequest = !ready_q | (avs_write & (idx == 3'd2) & cmd_full);
  assign wr_acc          = avs_write & !avs_waitrequest;
  assign rd_acc          = avs_read & !avs_write & !avs_waitrequest;

  assign cmd_push     = wr_acc & (idx == 3'd2);
  assign cmd_pop      = cmd_ready & !cmd_empty;
  assign resp_push    = resp_valid & !resp_full;
  assign resp_pop_req = rd_acc & (idx == 3'd3);
  assign resp_pop     = resp_pop_req & !resp_empty;

  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;
  assign go_pulse          = go_q;
  assign irq               = irq_en_q & done_q;
  assign cmd_data          = cmd_mem[cmd_rptr_q];
  assign cmd_valid         = !cmd_empty;
  assign resp_ready        = !resp_full;

  // Read data multiplexer over the register map
  always_comb begin
    rd_mux = '0;
    case (idx)
      3'd0: rd_mux[1] = irq_en_q;
      3'd1: begin
        rd_mux[0]     = done_q;
        rd_mux[1]     = cmd_full;
        rd_mux[2]     = resp_empty;
        rd_mux[3]     = underflow_q;
        rd_mux[15:8]  = 8'(cmd_cnt_q);
        rd_mux[23:16] = 8'(resp_cnt_q);
      end
      3'd3: rd_mux = resp_empty ? '0 : resp_mem[resp_rptr_q];
      3'd4, 3'd5, 3'd6, 3'd7: rd_mux = scratch_q[idx[1:0]];
      default: rd_mux = '0;
    endcase
  end

  // Next-state for registers, sticky flags and FIFO pointers/counts
  always_comb begin
    ready_d     = 1'b1;
    irq_en_d    = irq_en_q;
    go_d        = wr_acc & (idx == 3'd0) & avs_byteenable[0] & avs_writedata[0];
    rvalid_d    = rd_acc;
    rdata_d     = rd_acc ? rd_mux : '0;
    scratch_d   = scratch_q;
    cmd_wptr_d  = cmd_wptr_q;
    cmd_rptr_d  = cmd_rptr_q;
    cmd_cnt_d   = cmd_cnt_q;
    resp_wptr_d = resp_wptr_q;
    resp_rptr_d = resp_rptr_q;
    resp_cnt_d  = resp_cnt_q;

    if (wr_acc && idx == 3'd0 && avs_byteenable[0]) irq_en_d = avs_writedata[1];

    // Set beats clear when both land on the same edge
    done_d = done_in | (done_q &
             !(wr_acc && idx == 3'd1 && avs_byteenable[0] && avs_writedata[0]));
    underflow_d = (resp_pop_req & resp_empty) | (underflow_q &
             !(wr_acc && idx == 3'd1 && avs_byteenable[0] && avs_writedata[3]));

    if (wr_acc && idx[2]) begin
      for (int b = 0; b < 4; b++) begin
        if (avs_byteenable[b]) scratch_d[idx[1:0]][8*b +: 8] = avs_writedata[8*b +: 8];
      end
    end

    if (cmd_push) cmd_wptr_d = cmd_wptr_q + PW'(1);
    if (cmd_pop)  cmd_rptr_d = cmd_rptr_q + PW'(1);
    case ({cmd_push, cmd_pop})
      2'b10:   cmd_cnt_d = cmd_cnt_q + CW'(1);
      2'b01:   cmd_cnt_d = cmd_cnt_q - CW'(1);
      default: cmd_cnt_d = cmd_cnt_q;
    endcase

    if (resp_push) resp_wptr_d = resp_wptr_q + PW'(1);
    if (resp_pop)  resp_rptr_d = resp_rptr_q + PW'(1);
    case ({resp_push, resp_pop})
      2'b10:   resp_cnt_d = resp_cnt_q + CW'(1);
      2'b01:   resp_cnt_d = resp_cnt_q - CW'(1);
      default: resp_cnt_d = resp_cnt_q;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q     <= 1'b0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
      go_q        <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      for (int i = 0; i < 4; i++) scratch_q[i] <= '0;
      cmd_wptr_q  <= '0;
      cmd_rptr_q  <= '0;
      cmd_cnt_q   <= '0;
      resp_wptr_q <= '0;
      resp_rptr_q <= '0;
      resp_cnt_q  <= '0;
    end else begin
      ready_q     <= ready_d;
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      underflow_q <= underflow_d;
      go_q        <= go_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      scratch_q   <= scratch_d;
      cmd_wptr_q  <= cmd_wptr_d;
      cmd_rptr_q  <= cmd_rptr_d;
      cmd_cnt_q   <= cmd_cnt_d;
      resp_wptr_q <= resp_wptr_d;
      resp_rptr_q <= resp_rptr_d;
      resp_cnt_q  <= resp_cnt_d;
    end
  end

  // FIFO storage; validity is tracked by pointers and counts, so no reset needed
  always_ff @(posedge clk) begin
    if (cmd_push)  cmd_mem[cmd_wptr_q]   <= avs_writedata;
    if (resp_push) resp_mem[resp_wptr_q] <= resp_data;
  end

endmodule

// File: tb/tb_avalonmm_mailbox_slave.sv
// tb/tb_avalonmm_mailbox_slave.sv - directed self-checking bench for avalonmm_mailbox_slave
module tb_avalonmm_mailbox_slave;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] avs_address = '0;
  logic [31:0] avs_writedata = '0;
  logic        avs_write = 1'b0;
  logic        avs_read = 1'b0;
  logic [3:0]  avs_byteenable = '0;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        avs_waitrequest;
  logic        go_pulse;
  logic        done_in = 1'b0;
  logic        irq;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [31:0] resp_data = '0;
  logic        resp_valid = 1'b0;
  logic        resp_ready;

  int checks = 0;
  int errors = 0;

  avalonmm_mailbox_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .avs_address(avs_address), .avs_writedata(avs_writedata),
    .avs_write(avs_write), .avs_read(avs_read), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .avs_waitrequest(avs_waitrequest), .go_pulse(go_pulse), .done_in(done_in),
    .irq(irq), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .resp_data(resp_data), .resp_valid(resp_valid), .resp_ready(resp_ready)
  );

  always #5 clk = ~clk;

  task automatic wait_ready(input string name);
    int n = 0;
    #1;
    while (avs_waitrequest && n < 50) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL %s waitrequest stuck high after %0d cycles, required low", name, n); end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
    wait_ready("write_wait");
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
    @(negedge clk);
    avs_address = a; avs_read = 1'b1;
    wait_ready("read_wait");
    @(posedge clk); #1;
    avs_read = 1'b0;
    @(negedge clk);
    d = avs_readdata; v = avs_readdatavalid;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({avs_waitrequest, avs_readdatavalid, go_pulse, irq, cmd_valid, resp_ready} !== 6'b100001 || avs_readdata !== 32'h0) begin
      errors++; $display("FAIL reset_outputs got wr=%b rv=%b go=%b irq=%b cv=%b rr=%b rd=%h required 1 0 0 0 0 1 0",
        avs_waitrequest, avs_readdatavalid, go_pulse, irq, cmd_valid, resp_ready, avs_readdata);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (avs_waitrequest !== 1'b1) begin errors++; $display("FAIL wait_first_edge got %b required 1", avs_waitrequest); end
    @(negedge clk);
    checks++;
    if (avs_waitrequest !== 1'b0) begin errors++; $display("FAIL wait_after_edge got %b required 0", avs_waitrequest); end
  endtask

  task automatic test_status_reset;
    logic [31:0] d; logic v;
    bus_read(32'h4, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'h0000_0004) begin errors++; $display("FAIL status_reset got v=%b d=%h required v=1 d=00000004", v, d); end
  endtask

  task automatic test_scratch;
    logic [31:0] d; logic v;
    logic [31:0] exp [4];
    bus_write(32'hFFFF_FFF4, 32'hAABB_CCDD, 4'b0101);
    bus_read(32'h0000_0017, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'h00BB_00DD) begin errors++; $display("FAIL scratch1_byteen got v=%b d=%h required v=1 d=00bb00dd", v, d); end
    bus_write(32'h10, 32'h0102_0304, 4'hF);
    bus_write(32'h18, 32'h5566_7788, 4'hF);
    bus_write(32'h1C, 32'hCAFE_F00D, 4'b1000);
    exp[0] = 32'h0102_0304; exp[1] = 32'h00BB_00DD; exp[2] = 32'h5566_7788; exp[3] = 32'hCA00_0000;
    @(negedge clk);
    avs_read = 1'b1; avs_address = 32'h10;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (avs_readdatavalid !== 1'b1 || avs_readdata !== exp[k-1]) begin
        errors++; $display("FAIL scratch_b2b_%0d got v=%b d=%h required v=1 d=%h", k-1, avs_readdatavalid, avs_readdata, exp[k-1]);
      end
      if (k < 4) avs_address = 32'h10 + 32'(4 * k);
      else avs_read = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (avs_readdatavalid !== 1'b0) begin errors++; $display("FAIL scratch_b2b_end got v=%b required 0", avs_readdatavalid); end
  endtask

  task automatic test_cmd_fifo;
    logic [31:0] d; logic v;
    for (int i = 1; i <= 8; i++) bus_write(32'h8, 32'(i), 4'h0);
    bus_read(32'h4, d, v);
    checks++;
    if (d !== 32'h0000_0806 || cmd_valid !== 1'b1 || cmd_data !== 32'd1) begin
      errors++; $display("FAIL cmd_full_status got st=%h cv=%b cd=%h required st=00000806 cv=1 cd=1", d, cmd_valid, cmd_data);
    end
    @(negedge clk);
    avs_address = 32'h8; avs_writedata = 32'd9; avs_write = 1'b1; cmd_ready = 1'b1;
    #1;
    checks++;
    if (avs_waitrequest !== 1'b1) begin errors++; $display("FAIL cmd_stall got %b required 1", avs_waitrequest); end
    @(negedge clk);
    cmd_ready = 1'b0;
    #1;
    checks++;
    if (avs_waitrequest !== 1'b0 || cmd_data !== 32'd2) begin
      errors++; $display("FAIL cmd_stall_release got wr=%b cd=%h required wr=0 cd=2", avs_waitrequest, cmd_data);
    end
    @(posedge clk); #1;
    avs_write = 1'b0;
    for (int e = 2; e <= 9; e++) begin
      @(negedge clk);
      checks++;
      if (cmd_valid !== 1'b1 || cmd_data !== 32'(e)) begin
        errors++; $display("FAIL cmd_pop_%0d got cv=%b cd=%h required cv=1 cd=%h", e, cmd_valid, cmd_data, 32'(e));
      end
      cmd_ready = 1'b1;
    end
    @(negedge clk);
    cmd_ready = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0) begin errors++; $display("FAIL cmd_empty got cv=%b required 0", cmd_valid); end
  endtask

  task automatic test_resp_fifo;
    logic [31:0] d; logic v;
    logic [31:0] exp [3];
    exp[0] = 32'h11; exp[1] = 32'h22; exp[2] = 32'h0;
    @(negedge clk); resp_data = 32'h11; resp_valid = 1'b1;
    @(negedge clk); resp_data = 32'h22;
    @(negedge clk); resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_read(32'hC, d, v);
      checks++;
      if (v !== 1'b1 || d !== exp[i]) begin errors++; $display("FAIL resp_pop_%0d got v=%b d=%h required v=1 d=%h", i, v, d, exp[i]); end
    end
    bus_read(32'h4, d, v);
    checks++;
    if (d !== 32'h0000_000C) begin errors++; $display("FAIL underflow_set got %h required 0000000c", d); end
    bus_write(32'h4, 32'h8, 4'h1);
    bus_read(32'h4, d, v);
    checks++;
    if (d !== 32'h0000_0004) begin errors++; $display("FAIL underflow_clear got %h required 00000004", d); end
    // pop of empty FIFO coinciding with a core push
    @(negedge clk);
    avs_address = 32'hC; avs_read = 1'b1; resp_data = 32'h33; resp_valid = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0; resp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (avs_readdatavalid !== 1'b1 || avs_readdata !== 32'h0) begin
      errors++; $display("FAIL pop_push_empty got v=%b d=%h required v=1 d=0", avs_readdatavalid, avs_readdata);
    end
    bus_read(32'h4, d, v);
    checks++;
    if (d !== 32'h0001_0008) begin errors++; $display("FAIL pop_push_status got %h required 00010008", d); end
    bus_read(32'hC, d, v);
    checks++;
    if (d !== 32'h33) begin errors++; $display("FAIL pop_push_word got %h required 00000033", d); end
    bus_write(32'h4, 32'h8, 4'h1);
  endtask

  task automatic test_go_irq;
    logic [31:0] d; logic v;
    bus_write(32'h0, 32'h3, 4'h1);
    checks++;
    if (go_pulse !== 1'b1) begin errors++; $display("FAIL go_high got %b required 1", go_pulse); end
    @(posedge clk); #1;
    checks++;
    if (go_pulse !== 1'b0) begin errors++; $display("FAIL go_low got %b required 0", go_pulse); end
    bus_read(32'h0, d, v);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL ctrl_read got %h required 00000002", d); end
    @(negedge clk); done_in = 1'b1;
    @(posedge clk); #1; done_in = 1'b0;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b required 1", irq); end
    @(negedge clk);
    avs_address = 32'h4; avs_writedata = 32'h1; avs_byteenable = 4'h1; avs_write = 1'b1; done_in = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0; done_in = 1'b0;
    bus_read(32'h4, d, v);
    checks++;
    if (d !== 32'h5 || irq !== 1'b1) begin errors++; $display("FAIL done_set_wins got st=%h irq=%b required st=00000005 irq=1", d, irq); end
    bus_write(32'h4, 32'h1, 4'h1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b required 0", irq); end
  endtask

  task automatic test_conflict_and_reset;
    logic [31:0] d; logic v;
    @(negedge clk);
    avs_address = 32'h10; avs_writedata = 32'h1234_5678; avs_byteenable = 4'hF;
    avs_write = 1'b1; avs_read = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0; avs_read = 1'b0;
    @(negedge clk);
    checks++;
    if (avs_readdatavalid !== 1'b0) begin errors++; $display("FAIL rw_conflict_valid got %b required 0", avs_readdatavalid); end
    bus_read(32'h10, d, v);
    checks++;
    if (d !== 32'h1234_5678) begin errors++; $display("FAIL rw_conflict_write got %h required 12345678", d); end
    bus_write(32'h8, 32'hDEAD, 4'hF);
    @(negedge clk);
    avs_address = 32'h10; avs_read = 1'b1;
    #2 reset_n = 1'b0;
    @(posedge clk); #1;
    avs_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (avs_readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_cancel_%0d got %b required 0", i, avs_readdatavalid); end
    end
    checks++;
    if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_flush got cv=%b required 0", cmd_valid); end
    reset_n = 1'b1;
    bus_read(32'h10, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL reset_scratch got v=%b d=%h required v=1 d=0", v, d); end
  endtask

  initial begin
    test_reset();
    test_status_reset();
    test_scratch();
    test_cmd_fifo();
    test_resp_fifo();
    test_go_irq();
    test_conflict_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalonmm_mailbox_slave.md
# avalonmm_mailbox_slave

Avalon-MM responder (slave) terminating the multiplexed master port that is shared by the RF controller and the RISC-V controller. It exposes a small control/status register bank, four scratch registers, a host-to-core command FIFO and a core-to-host response FIFO. Reads have a fixed one-cycle latency signalled by `readdatavalid`. `waitrequest` is used only to back-pressure command pushes into a full FIFO.

## Interface
- `DATA_WIDTH`, 32: data bus width; must be 32.
- `ADDR_WIDTH`, 32: address width. Byte address; only `address[4:2]` is decoded, `address[ADDR_WIDTH-1:5]` and `address[1:0]` are ignored.
- `FIFO_DEPTH`, 8: depth of each FIFO. Power of two, 2..128.
- `clk` in 1: single clock.
- `reset_n` in 1: reset; asynchronous and active-low.
- `avs_address` in ADDR_WIDTH: byte address.
- `avs_writedata` in DATA_WIDTH: write data.
- `avs_write` in 1: write request.
- `avs_read` in 1: read request.
- `avs_byteenable` in 4: byte lanes.
- `avs_readdata` out DATA_WIDTH: read data, registered.
- `avs_readdatavalid` out 1: read data valid.
- `avs_waitrequest` out 1: stall.
- `go_pulse` out 1: one-cycle start strobe to the core.
- `done_in` in 1: core completion pulse.
- `irq` out 1: level interrupt, equal to `irq_en & done`.
- `cmd_data` out DATA_WIDTH: head of the command FIFO (show-ahead).
- `cmd_valid` out 1: command FIFO not empty.
- `cmd_ready` in 1: core pops when `cmd_valid & cmd_ready`.
- `resp_data` in DATA_WIDTH: response word.
- `resp_valid` in 1: core push request.
- `resp_ready` out 1: response FIFO not full.

## Operation
Register map (word index = `address[4:2]`):
- 0 CTRL:
  - bit0 GO: writing 1 with `byteenable[0]` set pulses `go_pulse` for one cycle. Always reads 0.
  - bit1 IRQ_EN: read/write.
- 1 STATUS:
  - bit0 DONE: sticky; set by `done_in`; write-1-to-clear.
  - bit1 CMD_FULL: read-only.
  - bit2 RESP_EMPTY: read-only.
  - bit3 UNDERFLOW: sticky; write-1-to-clear.
  - [15:8] command count: read-only.
  - [23:16] response count: read-only.
  - W1C bits honour `byteenable[0]`.
- 2 CMD_PUSH: a write pushes the full `writedata`; `byteenable` is ignored. Reads 0.
- 3 RESP_POP: a read returns the FIFO head and pops it. If the FIFO is empty, the read returns 0 and sets UNDERFLOW. Writes are ignored.
- 4..7 SCRATCH0..3: read/write, per-byte `byteenable`.

Arbitration and conflict rules:
- A write is accepted when `avs_write & !avs_waitrequest`. A read is accepted when `avs_read & !avs_waitrequest`.
- If `avs_read` and `avs_write` are asserted together, the write wins. The read is dropped and no `readdatavalid` is produced.
- If `done_in` coincides with a W1C of DONE, set wins and DONE stays 1. The same applies to UNDERFLOW versus its clear.

FIFO rules:
- FIFOs are circular. Pointers are log2(FIFO_DEPTH) bits and wrap. Counts are log2(FIFO_DEPTH)+1 bits, zero-extended into their STATUS fields.
- A host push to the command FIFO and a core pop on the same cycle are both performed.
- A core push to the response FIFO and a host pop on the same cycle are both performed. Emptiness is judged on registered state, so a pop of an empty FIFO with a simultaneous push returns 0, sets UNDERFLOW, and the pushed word is stored.
- `resp_valid` while the response FIFO is full: the word is dropped and the count is unchanged.
- `cmd_ready` while the command FIFO is empty: no effect.

## Timing
- Reset values:
  - Outputs: `avs_readdata`=0, `avs_readdatavalid`=0, `go_pulse`=0, `irq`=0, `cmd_valid`=0, `resp_ready`=1.
  - Internal state: all registers 0, both FIFOs empty.
  - `avs_waitrequest`=1 while reset is held and on the first rising edge after release. An internal ready flag sets on that edge.
- `avs_waitrequest` is combinational: `!ready | (avs_write & (addr==2) & cmd_full)`. `cmd_full` is registered state. A pop on the same cycle does not release the stall.
- Read accepted at edge N: `avs_readdata`/`avs_readdatavalid` are valid for exactly the cycle after edge N. Back-to-back reads give back-to-back valids. `readdatavalid` never asserts without an accepted read.
- `go_pulse` is high for the one cycle after the accepting edge.
- `done_in` at edge N: DONE=1 and `irq` (if IRQ_EN) after edge N.
- `cmd_valid` rises the cycle after the push edge.
- Asserting `reset_n` low mid-transaction: outputs go to reset values immediately. A pending `readdatavalid` is cancelled and FIFO contents are discarded.

## Test plan
- Reset, then release: `waitrequest`=1 for the first edge, then 0. Read STATUS -> 0x00000004 one cycle later with `readdatavalid`.
- Write SCRATCH1=0xAABBCCDD with `byteenable`=4'b0101, then read -> 0x00BB00DD. Back-to-back reads of SCRATCH0..3 -> four consecutive valids.
- Push 8 commands 1..8: the 9th write stalls (`waitrequest`=1). With `cmd_ready`=1 for one cycle, the stall holds that cycle, the 9th is accepted next, and pop order is 1..9 (wrap-around).
- Core pushes 0x11, 0x22. Host reads RESP_POP three times -> 0x11, 0x22, 0. STATUS then shows UNDERFLOW=1; W1C 0x8 clears it.
- Write CTRL=0x3 -> `go_pulse` for one cycle. `done_in` pulse -> `irq`=1. Write STATUS=1 on the same cycle as a `done_in` -> DONE stays 1. A later clear -> `irq`=0.
- Read and write asserted together to SCRATCH0 -> write takes effect, no `readdatavalid`. Reset asserted mid-read -> `readdatavalid` never appears.
